// File: rtl/req_ack_checker.sv
// req_ack_checker: passive per-channel req/ack latency-window monitor with event pulses,
// sticky error flags and saturating counters. Define REQ_ACK_CHECKER_ASSERT_EN to add SVA checks.
module req_ack_checker #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned MIN_LAT = 1,
    parameter int unsigned MAX_LAT = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] ack,
    input  logic              clear,
    output logic [NUM_CH-1:0] pass,
    output logic [NUM_CH-1:0] err_early,
    output logic [NUM_CH-1:0] err_timeout,
    output logic [NUM_CH-1:0] err_spurious,
    output logic [NUM_CH-1:0] err_sticky,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);
    localparam int unsigned LAT_W = 8;
    localparam int unsigned SUM_W = CNT_W + 8;
    localparam logic [LAT_W-1:0] MIN_L   = LAT_W'(MIN_LAT);
    localparam logic [LAT_W-1:0] MAX_L   = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [LAT_W-1:0]  lat_q   [NUM_CH];
    logic [LAT_W-1:0]  lat_d   [NUM_CH];

    logic [NUM_CH-1:0] pass_d, early_d, timeout_d, spurious_d;
    logic [NUM_CH-1:0] pass_q, early_q, timeout_q, spurious_q;
    logic [NUM_CH-1:0] err_any;
    logic [NUM_CH-1:0] err_sticky_d, err_sticky_q;
    logic [SUM_W-1:0]  pass_sum, fail_sum;
    logic [CNT_W-1:0]  pass_cnt_d, pass_cnt_q, fail_cnt_d, fail_cnt_q;

    // Channel FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                lat_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                lat_q[i]   <= lat_d[i];
            end
        end
    end

    // Next state: a completion cycle frees the channel, and a req in that same cycle re-arms it
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            lat_d[i]   = lat_q[i];
            if (state_q[i] == IDLE) begin
                if (req[i]) begin
                    state_d[i] = WAIT;
                    lat_d[i]   = LAT_ONE;
                end
            end else if (ack[i] || (lat_q[i] == MAX_L)) begin
                state_d[i] = req[i] ? WAIT : IDLE;
                lat_d[i]   = req[i] ? LAT_ONE : '0;
            end else begin
                lat_d[i] = lat_q[i] + LAT_ONE;
            end
        end
    end

    // Per-channel event decode
    always_comb begin
        pass_d     = '0;
        early_d    = '0;
        timeout_d  = '0;
        spurious_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (state_q[i] == IDLE) begin
                spurious_d[i] = ack[i];
            end else if (ack[i]) begin
                early_d[i] = (lat_q[i] < MIN_L);
                pass_d[i]  = (lat_q[i] >= MIN_L);
            end else begin
                timeout_d[i] = (lat_q[i] == MAX_L);
            end
        end
    end

    // Sticky flags and saturating counters; clear takes priority over same-cycle events
    always_comb begin
        err_any  = early_d | timeout_d | spurious_d;
        pass_sum = SUM_W'(pass_cnt_q) + SUM_W'($countones(pass_d));
        fail_sum = SUM_W'(fail_cnt_q) + SUM_W'($countones(early_d))
                 + SUM_W'($countones(timeout_d)) + SUM_W'($countones(spurious_d));
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        err_sticky_d = err_sticky_q;
        if (clear) begin
            pass_cnt_d   = '0;
            fail_cnt_d   = '0;
            err_sticky_d = '0;
        end else begin
            pass_cnt_d   = (pass_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : pass_sum[CNT_W-1:0];
            fail_cnt_d   = (fail_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : fail_sum[CNT_W-1:0];
            err_sticky_d = err_sticky_q | err_any;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q       <= '0;
            early_q      <= '0;
            timeout_q    <= '0;
            spurious_q   <= '0;
            err_sticky_q <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
        end else begin
            pass_q       <= pass_d;
            early_q      <= early_d;
            timeout_q    <= timeout_d;
            spurious_q   <= spurious_d;
            err_sticky_q <= err_sticky_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    assign pass         = pass_q;
    assign err_early    = early_q;
    assign err_timeout  = timeout_q;
    assign err_spurious = spurious_q;
    assign err_sticky   = err_sticky_q;
    assign pass_cnt     = pass_cnt_q;
    assign fail_cnt     = fail_cnt_q;

`ifdef REQ_ACK_CHECKER_ASSERT_EN
    if (MIN_LAT < 1 || MAX_LAT < MIN_LAT || MAX_LAT > 255) begin : g_param_chk
        $error("req_ack_checker: illegal latency window %0d..%0d", MIN_LAT, MAX_LAT);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sva
        property p_req_ack;
            @(posedge clk) disable iff (!rst_n)
                (state_q[g] == IDLE && req[g]) |-> ##[MIN_LAT:MAX_LAT] ack[g];
        endproperty
        a_req_ack: assert property (p_req_ack)
            $info("req_ack_checker: ch %0d ack in window at %0t", g, $time);
        else
            $error("req_ack_checker: ch %0d ack outside window at %0t", g, $time);
    end
`endif

endmodule

// File: tb/tb_req_ack_checker.sv
// Bench for req_ack_checker: three parameter sets driven in parallel, checked every cycle
// against a timestamp-based model, plus literal expectations from hand-worked sequences.
module tb_req_ack_checker;
    localparam int NCFG = 3;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [3:0] req;
    logic [3:0] ack;

    logic [3:0] pass_o  [NCFG];
    logic [3:0] early_o [NCFG];
    logic [3:0] tout_o  [NCFG];
    logic [3:0] spur_o  [NCFG];
    logic [3:0] stk_o   [NCFG];
    logic [7:0] pc0, fc0;
    logic [2:0] pc1, fc1;
    logic [1:0] pc2, fc2;

    req_ack_checker #(.NUM_CH(4), .MIN_LAT(1), .MAX_LAT(4), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .clear(clear),
        .pass(pass_o[0]), .err_early(early_o[0]), .err_timeout(tout_o[0]),
        .err_spurious(spur_o[0]), .err_sticky(stk_o[0]), .pass_cnt(pc0), .fail_cnt(fc0));

    req_ack_checker #(.NUM_CH(4), .MIN_LAT(2), .MAX_LAT(5), .CNT_W(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .clear(clear),
        .pass(pass_o[1]), .err_early(early_o[1]), .err_timeout(tout_o[1]),
        .err_spurious(spur_o[1]), .err_sticky(stk_o[1]), .pass_cnt(pc1), .fail_cnt(fc1));

    req_ack_checker #(.NUM_CH(4), .MIN_LAT(1), .MAX_LAT(1), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .clear(clear),
        .pass(pass_o[2]), .err_early(early_o[2]), .err_timeout(tout_o[2]),
        .err_spurious(spur_o[2]), .err_sticky(stk_o[2]), .pass_cnt(pc2), .fail_cnt(fc2));

    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Model: per channel an outstanding flag and the cycle number of the accepted request
    int         cyc;
    bit         outst   [NCFG][4];
    int         req_cyc [NCFG][4];
    logic [3:0] e_pass  [NCFG];
    logic [3:0] e_early [NCFG];
    logic [3:0] e_tout  [NCFG];
    logic [3:0] e_spur  [NCFG];
    logic [3:0] e_stk   [NCFG];
    int         e_pc    [NCFG];
    int         e_fc    [NCFG];

    function automatic int min_l(input int c);
        case (c)
            0:       return 1;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int max_l(input int c);
        case (c)
            0:       return 4;
            1:       return 5;
            default: return 1;
        endcase
    endfunction

    function automatic int cmax(input int c);
        case (c)
            0:       return 255;
            1:       return 7;
            default: return 3;
        endcase
    endfunction

    function automatic int got_pc(input int c);
        case (c)
            0:       return int'(pc0);
            1:       return int'(pc1);
            default: return int'(pc2);
        endcase
    endfunction

    function automatic int got_fc(input int c);
        case (c)
            0:       return int'(fc0);
            1:       return int'(fc1);
            default: return int'(fc2);
        endcase
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int c = 0; c < NCFG; c++) begin
            e_pass[c] = '0; e_early[c] = '0; e_tout[c] = '0; e_spur[c] = '0; e_stk[c] = '0;
            e_pc[c] = 0; e_fc[c] = 0;
            for (int ch = 0; ch < 4; ch++) begin
                outst[c][ch]   = 1'b0;
                req_cyc[c][ch] = 0;
            end
        end
    endtask

    task automatic model_step();
        int np;
        int nf;
        int l;
        bit free;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cyc++;
        for (int c = 0; c < NCFG; c++) begin
            e_pass[c] = '0; e_early[c] = '0; e_tout[c] = '0; e_spur[c] = '0;
            for (int ch = 0; ch < 4; ch++) begin
                free = 1'b0;
                if (!outst[c][ch]) begin
                    if (ack[ch]) e_spur[c][ch] = 1'b1;
                    free = 1'b1;
                end else begin
                    l = cyc - req_cyc[c][ch];
                    if (ack[ch]) begin
                        if (l < min_l(c)) e_early[c][ch] = 1'b1;
                        else              e_pass[c][ch]  = 1'b1;
                        free = 1'b1;
                    end else if (l == max_l(c)) begin
                        e_tout[c][ch] = 1'b1;
                        free = 1'b1;
                    end
                end
                if (free) begin
                    outst[c][ch] = req[ch];
                    if (req[ch]) req_cyc[c][ch] = cyc;
                end
            end
            np = $countones(e_pass[c]);
            nf = $countones(e_early[c]) + $countones(e_tout[c]) + $countones(e_spur[c]);
            if (clear) begin
                e_pc[c] = 0; e_fc[c] = 0; e_stk[c] = '0;
            end else begin
                e_pc[c]  = (e_pc[c] + np > cmax(c)) ? cmax(c) : e_pc[c] + np;
                e_fc[c]  = (e_fc[c] + nf > cmax(c)) ? cmax(c) : e_fc[c] + nf;
                e_stk[c] = e_stk[c] | e_early[c] | e_tout[c] | e_spur[c];
            end
        end
    endtask

    task automatic chk(input string name, input int c, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d cyc%0d: got 0x%0h expected 0x%0h", name, c, cyc, got, exp);
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NCFG; c++) begin
            chk("pass",         c, int'(pass_o[c]),  int'(e_pass[c]));
            chk("err_early",    c, int'(early_o[c]), int'(e_early[c]));
            chk("err_timeout",  c, int'(tout_o[c]),  int'(e_tout[c]));
            chk("err_spurious", c, int'(spur_o[c]),  int'(e_spur[c]));
            chk("err_sticky",   c, int'(stk_o[c]),   int'(e_stk[c]));
            chk("pass_cnt",     c, got_pc(c),        e_pc[c]);
            chk("fail_cnt",     c, got_fc(c),        e_fc[c]);
        end
    endtask

    // Drive at the falling edge, model at the rising edge, check at the next falling edge
    task automatic step(input logic [3:0] r, input logic [3:0] a, input logic clr);
        req   = r;
        ack   = a;
        clear = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'h0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; clear = 1'b0; req = '0; ack = '0;
        n_tests = 0; n_fail = 0;
        model_reset();
        idle(2);
        rst_n = 1'b1;

        // Default window, ch0: req then ack two samples later is a pass
        step(4'h1, 4'h0, 1'b0);
        step(4'h0, 4'h0, 1'b0);
        step(4'h0, 4'h1, 1'b0);
        chk("lit_pass0",    0, int'(pass_o[0]), 1);
        chk("lit_pcnt0",    0, int'(pc0), 1);
        chk("lit_fcnt0",    0, int'(fc0), 0);
        chk("lit_sticky0",  0, int'(stk_o[0]), 0);
        idle(6);

        // MIN_LAT=2, ch1: ack on the very next sample is early
        step(4'h2, 4'h0, 1'b0);
        step(4'h0, 4'h2, 1'b0);
        chk("lit_early1",   1, int'(early_o[1]), 2);
        chk("lit_sticky1",  1, int'(stk_o[1]), 2);
        chk("lit_fcnt1",    1, int'(fc1), 1);
        idle(6);

        // Default window, ch2: no ack times out on the fourth sample after the req
        step(4'h4, 4'h0, 1'b0);
        idle(3);
        chk("lit_no_tout_yet", 0, int'(tout_o[0]), 0);
        idle(1);
        chk("lit_tout2",    0, int'(tout_o[0]), 4);
        chk("lit_fcnt0b",   0, int'(fc0), 1);
        chk("lit_pcnt0b",   0, int'(pc0), 2);
        idle(6);

        // Strict next-cycle window: one acked request, two unacked, then a stray ack
        step(4'h1, 4'h0, 1'b0);
        step(4'h0, 4'h1, 1'b0);
        chk("lit_strict_pass",  2, int'(pass_o[2]), 1);
        step(4'h1, 4'h0, 1'b0);
        step(4'h0, 4'h0, 1'b0);
        chk("lit_strict_tout1", 2, int'(tout_o[2]), 1);
        step(4'h1, 4'h0, 1'b0);
        step(4'h0, 4'h0, 1'b0);
        chk("lit_strict_tout2", 2, int'(tout_o[2]), 1);
        step(4'h0, 4'h1, 1'b0);
        chk("lit_strict_spur",  2, int'(spur_o[2]), 1);
        idle(6);

        // CNT_W=2 saturation on ch3, then clear coinciding with a pass
        step(4'h0, 4'h0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(4'h8, 4'h0, 1'b0);
            step(4'h0, 4'h8, 1'b0);
        end
        chk("lit_sat_pcnt2", 2, int'(pc2), 3);
        step(4'h8, 4'h0, 1'b0);
        step(4'h0, 4'h8, 1'b1);
        chk("lit_clr_pass2", 2, int'(pass_o[2]), 8);
        chk("lit_clr_pcnt2", 2, int'(pc2), 0);
        chk("lit_clr_pcnt0", 0, int'(pc0), 0);
        idle(6);

        // Reset mid-WAIT aborts silently; a fresh request afterwards passes once
        step(4'h1, 4'h0, 1'b0);
        do_reset();
        step(4'h1, 4'h0, 1'b0);
        step(4'h0, 4'h1, 1'b0);
        chk("lit_rst_pass0", 0, int'(pass_o[0]), 1);
        chk("lit_rst_pcnt0", 0, int'(pc0), 1);
        idle(6);
        chk("lit_rst_fcnt0", 0, int'(fc0), 0);

        // Randomized traffic with occasional clear and reset
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            step(4'($urandom) & 4'($urandom), 4'($urandom) & 4'($urandom),
                 ($urandom_range(0, 63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
